stepper_pap_uni_driver: RTL

- Downstream stage of the quadrature encoder decoder: consumes its one-cycle step pulse and direction bit and drives the four coils of a unipolar stepper (PAP) motor.
- Accumulates requested steps as a signed net backlog, then executes them no faster than a programmable minimum step period.
- Supports wave, full and half-step sequencing and tracks absolute motor position.

---
 rtl/stepper_pkg.sv | 30 +++
 rtl/step_rate_timer.sv | 36 +++
 rtl/stepper_pap_uni_driver.sv | 110 +++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the unipolar stepper driver: mode encodings,
// the 8-entry coil phase table and the (idx, mode) -> coils lookup.
package stepper_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE = 2'b00,
    MODE_FULL = 2'b01,
    MODE_HALF = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Entry 0 sits in the low nibble; patterns are {A, B, A', B'}.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // Wave uses the even (single-coil) entries, full the odd (two-coil) ones,
  // so either mode lands on a valid pattern whatever idx currently holds.
  function automatic logic [3:0] phase_pattern(input logic [2:0] idx, input mode_e mode);
    logic [2:0] sel;
    case (mode)
      MODE_WAVE: sel = idx & 3'b110;
      MODE_FULL: sel = idx | 3'b001;
      default:   sel = idx;
    endcase
    return PHASE_TABLE[sel];
  endfunction

endpackage

// File: rtl/step_rate_timer.sv
// Minimum step spacing timer: counts up to STEP_PERIOD-1 and holds there
// (ready) until restarted by an executed step.
module step_rate_timer #(
  parameter int STEP_PERIOD = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic ready
);

  localparam int CW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ready = (cnt_q == LAST);

endmodule

// File: rtl/stepper_pap_uni_driver.sv
// Unipolar stepper coil driver: accumulates encoder step requests as a signed
// backlog and executes them at a bounded rate in wave, full or half-step mode.
module stepper_pap_uni_driver
  import stepper_pkg::*;
#(
  parameter int STEP_PERIOD = 100_000,
  parameter int PEND_W      = 5,
  parameter int POS_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_req,
  input  logic                     dir,
  input  logic [1:0]               mode,
  input  logic                     drv_en,
  input  logic                     clr_ovf,
  output logic [3:0]               coils,
  output logic signed [POS_W-1:0]  position,
  output logic signed [PEND_W-1:0] pending,
  output logic                     busy,
  output logic                     overflow
);

  localparam int PEND_MAX_I = (2 ** (PEND_W - 1)) - 1;
  localparam logic signed [PEND_W:0] PEND_MAX = PEND_MAX_I[PEND_W:0];
  localparam logic signed [PEND_W:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [PEND_W:0] ONE_EXT  = {{PEND_W{1'b0}}, 1'b1};

  logic [2:0]               idx_q, idx_d;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic                     ovf_q, ovf_d;
  logic [3:0]               coils_q, coils_d;

  mode_e                    mode_s;
  logic                     ready;
  logic                     exec;
  logic                     pend_neg;
  logic [2:0]               step_mag;
  logic signed [PEND_W:0]   exec_delta;
  logic signed [PEND_W:0]   req_delta;
  logic signed [PEND_W:0]   base;
  logic signed [PEND_W:0]   sum;
  logic                     drop;

  step_rate_timer #(
    .STEP_PERIOD(STEP_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(exec),
    .ready  (ready)
  );

  always_comb begin
    mode_s     = mode_e'(mode);
    pend_neg   = pend_q[PEND_W-1];
    exec       = ready & (pend_q != '0) & drv_en & (mode_s != MODE_HOLD);
    step_mag   = (mode_s == MODE_HALF) ? 3'd1 : 3'd2;

    idx_d      = idx_q;
    pos_d      = pos_q;
    exec_delta = '0;
    if (exec) begin
      idx_d      = pend_neg ? (idx_q - step_mag) : (idx_q + step_mag);
      pos_d      = pend_neg ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
      exec_delta = pend_neg ? '1 : ONE_EXT;
    end

    req_delta = '0;
    if (step_req) begin
      req_delta = dir ? ONE_EXT : '1;
    end

    // Executing a step only ever moves toward zero, so a drop can only
    // come from the incoming request pushing past the clamp.
    base   = {pend_q[PEND_W-1], pend_q} - exec_delta;
    sum    = base + req_delta;
    drop   = (sum > PEND_MAX) || (sum < PEND_MIN);
    pend_d = drop ? base[PEND_W-1:0] : sum[PEND_W-1:0];
    ovf_d  = drop | (ovf_q & ~clr_ovf);

    coils_d = (mode_s == MODE_HOLD) ? coils_q : phase_pattern(idx_d, mode_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      pos_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      coils_q <= '0;
    end else begin
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      coils_q <= coils_d;
    end
  end

  // Coils come straight from a cleared-by-reset flop, so reset drops them
  // to 0000 without passing through any intermediate pattern.
  assign coils    = drv_en ? coils_q : 4'b0000;
  assign position = pos_q;
  assign pending  = pend_q;
  assign busy     = (pend_q != '0);
  assign overflow = ovf_q;

endmodule
